// File: rtl/fsm_useq.sv
// Microsequenced control unit: runs one of 2^SEL_W writable microprograms, one control word per clock.
// Optional macro FSM_USEQ_STEP_EN adds a STEP input that gates advancement in RUN.
module fsm_useq #(
   parameter int unsigned SEL_W  = 2,
   parameter int unsigned STEP_W = 3,
   parameter int unsigned WORD_W = 13
) (
   input  logic                    CLK_MASTER,
   input  logic                    RST,
   input  logic [SEL_W-1:0]        selector,
   input  logic                    START,
`ifdef FSM_USEQ_STEP_EN
   input  logic                    STEP,
`endif
   input  logic                    WE,
   input  logic [SEL_W+STEP_W-1:0] WADDR,
   input  logic [WORD_W:0]         WDATA,
   output logic [WORD_W-1:0]       SALIDA,
   output logic                    BUSY,
   output logic                    DONE
);

   localparam int unsigned ADDR_W    = SEL_W + STEP_W;
   localparam int unsigned DEPTH     = 1 << ADDR_W;
   localparam int unsigned LAST_STEP = (1 << STEP_W) - 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [SEL_W-1:0]    prog_q, prog_d;
   logic [STEP_W-1:0]   step_q, step_d;
   logic                end_q, end_d;
   logic [WORD_W-1:0]   salida_q, salida_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;

   logic [WORD_W:0]     mem_q [DEPTH];

   logic                mem_we_c;
   logic                advance_c;
   logic [STEP_W-1:0]   step_inc_c;
   logic [ADDR_W-1:0]   start_addr_c;
   logic [WORD_W:0]     start_word_c;
   logic [WORD_W:0]     next_word_c;

`ifdef FSM_USEQ_STEP_EN
   assign advance_c = STEP;
`else
   assign advance_c = 1'b1;
`endif

   assign mem_we_c     = (state_q == S_IDLE) && WE;
   assign step_inc_c   = step_q + STEP_W'(1);
   assign start_addr_c = {selector, STEP_W'(0)};
   assign next_word_c  = mem_q[{prog_q, step_inc_c}];

   // A write landing on the same edge as START must be seen by step 0.
   always_comb begin
      if (mem_we_c && (WADDR == start_addr_c)) begin
         start_word_c = WDATA;
      end else begin
         start_word_c = mem_q[start_addr_c];
      end
   end

   // Microcode store; intentionally not cleared by reset.
   always_ff @(posedge CLK_MASTER) begin
      if (mem_we_c) begin
         mem_q[WADDR] <= WDATA;
      end
   end

   always_ff @(posedge CLK_MASTER) begin
      if (RST) begin
         state_q  <= S_IDLE;
         prog_q   <= '0;
         step_q   <= '0;
         end_q    <= 1'b0;
         salida_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         prog_q   <= prog_d;
         step_q   <= step_d;
         end_q    <= end_d;
         salida_q <= salida_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   // Next state plus next values of the registered outputs.
   always_comb begin
      state_d  = state_q;
      prog_d   = prog_q;
      step_d   = step_q;
      end_d    = end_q;
      salida_d = '0;
      busy_d   = 1'b0;
      done_d   = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (START) begin
               state_d  = S_RUN;
               prog_d   = selector;
               step_d   = '0;
               end_d    = start_word_c[WORD_W];
               salida_d = start_word_c[WORD_W-1:0];
               busy_d   = 1'b1;
            end
         end
         S_RUN: begin
            salida_d = salida_q;
            busy_d   = 1'b1;
            if (advance_c) begin
               if (end_q || (step_q == STEP_W'(LAST_STEP))) begin
                  state_d  = S_DONE;
                  step_d   = '0;
                  end_d    = 1'b0;
                  salida_d = '0;
                  busy_d   = 1'b0;
                  done_d   = 1'b1;
               end else begin
                  step_d   = step_inc_c;
                  end_d    = next_word_c[WORD_W];
                  salida_d = next_word_c[WORD_W-1:0];
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign SALIDA = salida_q;
   assign BUSY   = busy_q;
   assign DONE   = done_q;

endmodule

// File: tb/tb_fsm_useq.sv
// Directed self-checking bench for fsm_useq; covers FSM_USEQ_STEP_EN when that macro is defined.
module tb_fsm_useq;

   logic        clk;
   logic        rst;
   logic [1:0]  selector;
   logic        start;
   logic        we;
   logic [4:0]  waddr;
   logic [13:0] wdata;
   logic [12:0] salida;
   logic        busy;
   logic        done;
`ifdef FSM_USEQ_STEP_EN
   logic        step;
`endif

   int n_cmp;
   int n_bad;

   fsm_useq dut (
      .CLK_MASTER (clk),
      .RST        (rst),
      .selector   (selector),
      .START      (start),
`ifdef FSM_USEQ_STEP_EN
      .STEP       (step),
`endif
      .WE         (we),
      .WADDR      (waddr),
      .WDATA      (wdata),
      .SALIDA     (salida),
      .BUSY       (busy),
      .DONE       (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Advance one edge; inputs and samples then sit 1 time unit after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_out(input string tag, input logic [12:0] s, input logic b, input logic d);
      check({tag, ".salida"}, 32'(salida), 32'(s));
      check({tag, ".busy"},   32'(busy),   32'(b));
      check({tag, ".done"},   32'(done),   32'(d));
   endtask

   task automatic write_word(input int p, input int s, input logic [13:0] d);
      we    = 1'b1;
      waddr = 5'((p << 3) | s);
      wdata = d;
      tick();
      we    = 1'b0;
   endtask

   task automatic start_prog(input int p);
      selector = 2'(p);
      start    = 1'b1;
      tick();
      start    = 1'b0;
   endtask

   initial begin
      logic done_seen;
      n_cmp    = 0;
      n_bad    = 0;
      rst      = 1'b1;
      selector = '0;
      start    = 1'b0;
      we       = 1'b0;
      waddr    = '0;
      wdata    = '0;
`ifdef FSM_USEQ_STEP_EN
      step     = 1'b1;
`endif
      #1;
      tick();
      tick();
      rst = 1'b0;
      check_out("reset", 13'h0000, 1'b0, 1'b0);

      // Program 1: 0x0001, 0x0002, 0x1004|END
      write_word(1, 0, 14'h0001);
      write_word(1, 1, 14'h0002);
      write_word(1, 2, 14'h3004);
      // Program 3: 0x100..0x107, no END flag anywhere
      for (int k = 0; k < 8; k++) write_word(3, k, 14'(32'h100 + k));
      check_out("idle_after_writes", 13'h0000, 1'b0, 1'b0);

      start_prog(1);
      check_out("p1.w0", 13'h0001, 1'b1, 1'b0);
      tick(); check_out("p1.w1", 13'h0002, 1'b1, 1'b0);
      tick(); check_out("p1.w2", 13'h1004, 1'b1, 1'b0);
      tick(); check_out("p1.done", 13'h0000, 1'b0, 1'b1);
      tick(); check_out("p1.idle", 13'h0000, 1'b0, 1'b0);

      start_prog(3);
      for (int k = 0; k < 8; k++) begin
         check_out($sformatf("p3.w%0d", k), 13'(32'h100 + k), 1'b1, 1'b0);
         tick();
      end
      check_out("p3.done", 13'h0000, 1'b0, 1'b1);
      tick(); check_out("p3.idle", 13'h0000, 1'b0, 1'b0);

      // Writes while busy/done and START during DONE are all ignored
      start_prog(1);
      check_out("wr.w0", 13'h0001, 1'b1, 1'b0);
      we    = 1'b1;
      waddr = 5'((1 << 3) | 1);
      wdata = 14'h1FFF;
      tick(); check_out("wr.w1", 13'h0002, 1'b1, 1'b0);
      tick(); check_out("wr.w2", 13'h1004, 1'b1, 1'b0);
      tick(); check_out("wr.done", 13'h0000, 1'b0, 1'b1);
      selector = 2'd1;
      start    = 1'b1;
      tick();
      we    = 1'b0;
      start = 1'b0;
      check_out("wr.idle", 13'h0000, 1'b0, 1'b0);
      tick(); check_out("wr.no_restart", 13'h0000, 1'b0, 1'b0);
      start_prog(1);
      check_out("rerun.w0", 13'h0001, 1'b1, 1'b0);
      tick(); check_out("rerun.w1", 13'h0002, 1'b1, 1'b0);
      tick(); check_out("rerun.w2", 13'h1004, 1'b1, 1'b0);
      tick(); check_out("rerun.done", 13'h0000, 1'b0, 1'b1);
      tick();

      // Simultaneous write of {2,0} and START with selector=2
      we    = 1'b1;
      waddr = 5'(2 << 3);
      wdata = 14'h2AAA;
      start_prog(2);
      we = 1'b0;
      check_out("ws.w0", 13'h0AAA, 1'b1, 1'b0);
      tick(); check_out("ws.done", 13'h0000, 1'b0, 1'b1);
      tick(); check_out("ws.idle", 13'h0000, 1'b0, 1'b0);

`ifdef FSM_USEQ_STEP_EN
      start_prog(1);
      check_out("st.w0", 13'h0001, 1'b1, 1'b0);
      tick(); check_out("st.w1", 13'h0002, 1'b1, 1'b0);
      step = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         check_out($sformatf("st.hold%0d", k), 13'h0002, 1'b1, 1'b0);
      end
      step = 1'b1;
      tick(); check_out("st.w2", 13'h1004, 1'b1, 1'b0);
      tick(); check_out("st.done", 13'h0000, 1'b0, 1'b1);
      tick();
`endif

      // Reset mid-RUN abandons the program without a DONE pulse
      start_prog(3);
      tick(); check_out("rst.w1", 13'h0101, 1'b1, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_out("rst.mid", 13'h0000, 1'b0, 1'b0);
      done_seen = 1'b0;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (done || busy) done_seen = 1'b1;
      end
      check("rst.no_done", 32'(done_seen), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
